// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch, data and loader requesters, with a run/halt
// controller that stops core traffic once the core writes 1 to the tohost word.
module mem_arbiter #(
    parameter int unsigned           ADDR_W      = 32,
    parameter int unsigned           MAX_WAIT    = 4,
    parameter logic [ADDR_W-1:0]     TOHOST_ADDR = ADDR_W'(32'h0000_5000)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [31:0]         if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [3:0]          d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [31:0]         d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [31:0]         d_rdata,
    input  logic                ld_req,
    input  logic                ld_we,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [31:0]         ld_wdata,
    output logic                ld_gnt,
    output logic                ld_rvalid,
    output logic [31:0]         ld_rdata,
    output logic                mem_en,
    output logic [3:0]          mem_we,
    output logic [ADDR_W-3:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic [31:0]         mem_rdata,
    output logic                halted
);

    // state | meaning
    // RUN   | loader > data > fetch, fetch promoted over data after MAX_WAIT denials
    // HALT  | core completed via tohost write; only the loader is served
    typedef enum logic {RUN, HALT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D, OWN_LD} owner_t;

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    state_t           state_q, state_d;
    owner_t           owner_q, owner_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             promote;
    logic             tohost_wr;

    assign promote = if_req && (wait_q == CNT_W'(MAX_WAIT));

    always_comb begin
        state_d   = state_q;
        owner_d   = OWN_NONE;
        wait_d    = wait_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        ld_gnt    = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        tohost_wr = 1'b0;

        if (!rst) begin
            if (ld_req) begin
                ld_gnt = 1'b1;
            end else if (state_q == RUN) begin
                if (promote)      if_gnt = 1'b1;
                else if (d_req)   d_gnt  = 1'b1;
                else if (if_req)  if_gnt = 1'b1;
            end
        end

        if (ld_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ld_we ? 4'hF : 4'h0;
            mem_addr  = ld_addr[ADDR_W-1:2];
            mem_wdata = ld_wdata;
            owner_d   = ld_we ? OWN_NONE : OWN_LD;
        end else if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we ? d_be : 4'h0;
            mem_addr  = d_addr[ADDR_W-1:2];
            mem_wdata = d_wdata;
            owner_d   = d_we ? OWN_NONE : OWN_D;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr[ADDR_W-1:2];
            owner_d   = OWN_IF;
        end

        // Only a full-word core write of exactly 1 counts as completion.
        tohost_wr = d_gnt && d_we && (d_addr == TOHOST_ADDR) &&
                    (d_be == 4'hF) && (d_wdata == 32'd1);
        if (tohost_wr) state_d = HALT;

        if (state_q == HALT)
            wait_d = '0;
        else if (if_req && !if_gnt)
            wait_d = (wait_q == CNT_W'(MAX_WAIT)) ? wait_q : wait_q + CNT_W'(1);
        else
            wait_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            owner_q <= OWN_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wait_q  <= wait_d;
        end
    end

    // Gating by rst drops a read that was granted just before reset.
    assign if_rvalid = !rst && (owner_q == OWN_IF);
    assign d_rvalid  = !rst && (owner_q == OWN_D);
    assign ld_rvalid = !rst && (owner_q == OWN_LD);
    assign if_rdata  = if_rvalid ? mem_rdata : 32'h0;
    assign d_rdata   = d_rvalid  ? mem_rdata : 32'h0;
    assign ld_rdata  = ld_rvalid ? mem_rdata : 32'h0;
    assign halted    = (state_q == HALT);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0], ld_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, expected-grant stimulus and a
// read-response scoreboard checked every cycle.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, ld_req, ld_we;
    logic [31:0] if_addr, d_addr, d_wdata, ld_addr, ld_wdata;
    logic [3:0]  d_be;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, ld_gnt, ld_rvalid;
    logic [31:0] if_rdata, d_rdata, ld_rdata;
    logic        mem_en, halted;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halted(halted)
    );

    function automatic logic [31:0] pat(input int w);
        return {16'hC0DE, 16'(w)};
    endfunction

    // Behavioural RAM: unwritten words read back as pat(word).
    logic [31:0] ram [int];
    always @(posedge clk) begin
        if (mem_en) begin
            logic [31:0] cur;
            int w;
            w   = int'(mem_addr);
            cur = ram.exists(w) ? ram[w] : pat(w);
            mem_rdata <= cur;
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) cur[b*8 +: 8] = mem_wdata[b*8 +: 8];
            if (mem_we != 4'h0) ram[w] = cur;
        end
    end

    typedef struct {int cyc; int who; logic [31:0] data;} exp_t;
    exp_t        sb[$];
    logic [31:0] ref_mem [int];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] ref_rd(input int w);
        return ref_mem.exists(w) ? ref_mem[w] : pat(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // eg = expected grant {ld, d, if}; called right after a negedge with inputs set.
    task automatic tick(input logic [2:0] eg, input string tag);
        logic [2:0]  erv;
        logic [31:0] edat [3];
        logic [31:0] ea, cur;
        logic [3:0]  ewe;
        exp_t        e;
        int          w;
        #1;
        check({tag, "_gnt"}, {29'd0, ld_gnt, d_gnt, if_gnt}, {29'd0, eg});
        check({tag, "_mem_en"}, {31'd0, mem_en}, {31'd0, |eg});
        if (eg != 3'b000) begin
            if (eg[2])      begin ea = ld_addr; ewe = ld_we ? 4'hF : 4'h0; end
            else if (eg[1]) begin ea = d_addr;  ewe = d_we ? d_be : 4'h0;  end
            else            begin ea = if_addr; ewe = 4'h0;                end
            check({tag, "_mem_addr"}, {2'b00, mem_addr}, ea >> 2);
            check({tag, "_mem_we"}, {28'd0, mem_we}, {28'd0, ewe});
        end
        if (rst)
            while (sb.size() > 0 && sb[0].cyc == cyc) void'(sb.pop_front());
        erv = 3'b000;
        for (int i = 0; i < 3; i++) edat[i] = 32'h0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            erv[e.who]  = 1'b1;
            edat[e.who] = e.data;
        end
        check({tag, "_rvalid"}, {29'd0, ld_rvalid, d_rvalid, if_rvalid}, {29'd0, erv});
        check({tag, "_if_rdata"}, if_rdata, edat[0]);
        check({tag, "_d_rdata"}, d_rdata, edat[1]);
        check({tag, "_ld_rdata"}, ld_rdata, edat[2]);
        if (!rst) begin
            if (eg[2]) begin
                w = int'(ld_addr >> 2);
                if (ld_we) ref_mem[w] = ld_wdata;
                else sb.push_back('{cyc + 1, 2, ref_rd(w)});
            end else if (eg[1]) begin
                w = int'(d_addr >> 2);
                if (d_we) begin
                    cur = ref_rd(w);
                    for (int b = 0; b < 4; b++)
                        if (d_be[b]) cur[b*8 +: 8] = d_wdata[b*8 +: 8];
                    ref_mem[w] = cur;
                end else sb.push_back('{cyc + 1, 1, ref_rd(w)});
            end else if (eg[0]) begin
                sb.push_back('{cyc + 1, 0, ref_rd(int'(if_addr >> 2))});
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle_reqs();
        if_req = 0; d_req = 0; ld_req = 0; d_we = 0; ld_we = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; d_be = 4'hF; d_wdata = 0; ld_wdata = 0;
        if_addr = 32'h10; d_addr = 32'h20; ld_addr = 32'h30;
        idle_reqs();
        @(negedge clk);

        // Reset with every request high
        if_req = 1; d_req = 1; ld_req = 1;
        tick(3'b000, "rst0");
        tick(3'b000, "rst1");
        check("rst_halted", {31'd0, halted}, 32'd0);

        rst = 0; d_req = 0; ld_req = 0;
        tick(3'b001, "first_if");
        check("first_if_addr", {2'b00, mem_addr}, 32'd4);
        if_req = 0;
        tick(3'b000, "first_if_rv");

        // Priority: loader, data, fetch
        if_req = 1; d_req = 1; ld_req = 1;
        tick(3'b100, "prio_ld");
        ld_req = 0;
        tick(3'b010, "prio_d");
        d_req = 0;
        tick(3'b001, "prio_if");
        if_req = 0;
        tick(3'b000, "prio_drain");

        // Starvation: four data grants then one promoted fetch, twice
        d_req = 1; if_req = 1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) tick(3'b010, "starve_d");
            tick(3'b001, "starve_if");
        end
        idle_reqs();
        tick(3'b000, "starve_drain");

        // Tohost writes that must not halt
        d_req = 1; d_we = 1; d_addr = 32'h5000; d_be = 4'hF; d_wdata = 2;
        tick(3'b010, "nh_val2");
        check("nh_val2_halted", {31'd0, halted}, 32'd0);
        d_be = 4'h1; d_wdata = 1;
        tick(3'b010, "nh_be1");
        check("nh_be1_halted", {31'd0, halted}, 32'd0);
        d_req = 0; d_we = 0;
        ld_req = 1; ld_we = 1; ld_addr = 32'h5000; ld_wdata = 1;
        tick(3'b100, "nh_ld");
        check("nh_ld_halted", {31'd0, halted}, 32'd0);
        ld_we = 0; ld_addr = 32'h30;
        d_req = 1; d_we = 1; d_be = 4'hF; d_wdata = 1;
        tick(3'b100, "nh_ld_vs_tohost");
        check("nh_ld_vs_tohost_halted", {31'd0, halted}, 32'd0);
        idle_reqs();
        tick(3'b000, "nh_drain");

        // Fetch promotion beats a tohost write, which then retries and halts
        d_req = 1; d_we = 1; d_be = 4'hF; d_wdata = 2; if_req = 1;
        for (int k = 0; k < 4; k++) tick(3'b010, "promo_d");
        d_wdata = 1;
        tick(3'b001, "promo_if");
        check("promo_halted", {31'd0, halted}, 32'd0);
        if_req = 0;
        tick(3'b010, "halt_wr");
        check("halt_set", {31'd0, halted}, 32'd1);

        // Halted: only the loader is served
        d_we = 0; d_addr = 32'h20; d_req = 1; if_req = 1;
        for (int k = 0; k < 3; k++) tick(3'b000, "halt_block");
        ld_req = 1; ld_we = 0; ld_addr = 32'h5000;
        tick(3'b100, "halt_ld_rd");
        check("halt_tohost_ref", ref_rd(32'h1400), 32'd1);
        ld_req = 0;
        tick(3'b000, "halt_ld_rv");
        check("halt_sticky", {31'd0, halted}, 32'd1);

        // Reset clears halt; reset right after a data read grant drops its rvalid
        idle_reqs();
        rst = 1;
        tick(3'b000, "rst2a");
        tick(3'b000, "rst2b");
        rst = 0;
        check("rst_clears_halt", {31'd0, halted}, 32'd0);
        d_req = 1; d_addr = 32'h20;
        tick(3'b010, "midrd_d");
        d_req = 0; rst = 1;
        tick(3'b000, "midrd_rst");
        rst = 0;
        tick(3'b000, "midrd_after");
        check("midrd_halted", {31'd0, halted}, 32'd0);
        check("sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
